// File: rtl/rom_share_arb.sv
// Two-requester arbiter for the shared single-port RLE ROM.
// Video has priority; audio is forced through after MAX_WAIT denials.
module rom_share_arb #(
  parameter int          ADDR_W     = 18,
  parameter int          DATA_W     = 8,
  parameter int          MAX_WAIT   = 4,
  parameter logic [15:0] STARVE_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_gnt,
  output logic              v_valid,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [15:0]       starve_cnt
);

  logic [3:0] wait_cnt;
  logic       at_max;
  logic       forced;
  logic [1:0] tag1;
  logic [1:0] tag2;

  assign at_max = (wait_cnt == MAX_WAIT[3:0]);
  assign forced = v_req & a_req & at_max;

  // Same-cycle grant: video wins unless audio has waited its limit.
  assign v_gnt = ~rst & v_req & ~forced;
  assign a_gnt = ~rst & a_req & (~v_req | at_max);

  assign v_valid = tag2[1];
  assign a_valid = tag2[0];
  assign rd_data = rom_q;

  // Count consecutive audio denials; any audio win or idle audio clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (a_gnt || !a_req) begin
      wait_cnt <= '0;
    end else if (v_gnt) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Saturating tally of audio grants that had to be forced.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (forced && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 16'd1;
    end
  end

  // Register the winner's address; hold it when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
    end else if (v_gnt) begin
      rom_addr <= v_addr;
    end else if (a_gnt) begin
      rom_addr <= a_addr;
    end
  end

  // Ownership tags ride alongside the two-cycle ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1 <= 2'b00;
      tag2 <= 2'b00;
    end else begin
      tag1 <= {v_gnt, a_gnt};
      tag2 <= tag1;
    end
  end

endmodule
